// File: rtl/item_pkg.sv
// Shared definitions for the item slot manager.
// Holds the item word field positions, screen geometry, commit timing, the
// empty-slot word, the controller FSM state type and small field helpers.
// No ports.
package item_pkg;

  localparam int unsigned NUM_SLOTS    = 9;
  localparam int unsigned ITEM_W       = 14;
  localparam int unsigned SCREENSIZE_H = 16;
  localparam int unsigned SCREENSIZE_V = 12;

  // Item word fields: [13:10] ID, [9:8] orientation, [7:0] tile location.
  localparam int unsigned ID_MSB     = 13;
  localparam int unsigned ID_LSB     = 10;
  localparam int unsigned ORIENT_MSB = 9;
  localparam int unsigned ORIENT_LSB = 8;
  localparam int unsigned LOC_MSB    = 7;
  localparam int unsigned LOC_LSB    = 0;

  localparam logic [7:0]  SCREEN_TILES = 8'(SCREENSIZE_H * SCREENSIZE_V);
  localparam logic [9:0]  COMMIT_LINE  = 10'd480;
  localparam logic [3:0]  EMPTY_ID     = 4'hF;
  localparam logic [13:0] EMPTY_ITEM   = 14'h3C00;

  typedef logic [ITEM_W-1:0] item_t;
  typedef item_t [NUM_SLOTS-1:0] bank_t;

  typedef enum logic [1:0] {StOpen, StClear, StCommit} state_e;

  function automatic logic [3:0] item_id(item_t w);
    return w[ID_MSB:ID_LSB];
  endfunction

  function automatic logic [7:0] item_loc(item_t w);
    return w[LOC_MSB:LOC_LSB];
  endfunction

endpackage

// File: rtl/item_slot_manager_if.sv
// Update port of the item slot manager: a valid/ready handshake carrying a
// target slot (1..9) and a new 14-bit item word.
//   master: game logic (drives upd_valid, upd_slot, upd_item; sees upd_ready)
//   slave : item_slot_manager (drives upd_ready)
interface item_slot_manager_if;
  import item_pkg::*;

  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] upd_slot;
  item_t      upd_item;

  modport master (output upd_valid, output upd_slot, output upd_item, input upd_ready);
  modport slave  (input upd_valid, input upd_slot, input upd_item, output upd_ready);

endinterface

// File: rtl/item_slot_bank.sv
// Bank of NUM_SLOTS item registers.
// Ports:
//   clk, reset        clock and synchronous active-high reset (all slots empty)
//   wr_en/idx/data    single-slot write, wr_idx is 0-based
//   clear             set every slot to EMPTY_ITEM
//   load, load_data   copy a whole bank in at one edge
//   words             current register contents
// Priority: reset > clear > load > write.
module item_slot_bank
  import item_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  item_t      wr_data,
  input  logic       clear,
  input  logic       load,
  input  bank_t      load_data,
  output bank_t      words
);

  bank_t words_d, words_q;

  always_comb begin
    words_d = words_q;
    if (clear) begin
      words_d = {NUM_SLOTS{EMPTY_ITEM}};
    end else if (load) begin
      words_d = load_data;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (wr_idx == 4'(i)) words_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) words_q <= {NUM_SLOTS{EMPTY_ITEM}};
    else       words_q <= words_d;
  end

  assign words = words_q;

endmodule

// File: rtl/item_slot_manager.sv
// Item slot manager: double-buffered item channels for the frame-buffer
// controller. Updates land in a shadow bank; once per frame, at the first
// blanking line, the shadow is copied to the active bank that drives item_n.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   counter_V, counter_H    raster position; commit at (COMMIT_LINE, 0)
//   upd                     update handshake (slave side of item_slot_manager_if)
//   clear_all               request to empty the whole shadow bank
//   item_1..item_9          active-bank words (registered)
//   frame_commit            one-cycle pulse when new active words appear
//   upd_err                 sticky flag for rejected updates
//   collision               only with ITEM_COLLISION_CHECK_EN defined: two used
//                           slots shared a location at the last commit
module item_slot_manager
  import item_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  counter_V,
  input  logic [9:0]  counter_H,
  item_slot_manager_if.slave upd,
  input  logic        clear_all,
  output item_t       item_1,
  output item_t       item_2,
  output item_t       item_3,
  output item_t       item_4,
  output item_t       item_5,
  output item_t       item_6,
  output item_t       item_7,
  output item_t       item_8,
  output item_t       item_9,
  output logic        frame_commit,
  output logic        upd_err
`ifdef ITEM_COLLISION_CHECK_EN
  ,
  output logic        collision
`endif
);

  state_e state;
  logic   clear_pend;  // clear_all arrived together with commit_now
  bank_t  shadow_words, active_words;

  logic commit_now, upd_ready, upd_accept, slot_ok, loc_ok;

  assign commit_now = (counter_V == COMMIT_LINE) && (counter_H == 10'd0);
  assign upd_ready  = !reset && (state == StOpen) && !commit_now && !clear_all;
  assign upd.upd_ready = upd_ready;
  assign upd_accept = upd.upd_valid && upd_ready;

  assign slot_ok = (upd.upd_slot != 4'd0) && (upd.upd_slot <= 4'd9);
  assign loc_ok  = (item_id(upd.upd_item) == EMPTY_ID) || (item_loc(upd.upd_item) < SCREEN_TILES);

  item_slot_bank u_shadow (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (upd_accept && slot_ok && loc_ok),
    .wr_idx    (upd.upd_slot - 4'd1),
    .wr_data   (upd.upd_item),
    .clear     (state == StClear),
    .load      (1'b0),
    .load_data ({NUM_SLOTS{EMPTY_ITEM}}),
    .words     (shadow_words)
  );

  item_slot_bank u_active (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_idx    (4'd0),
    .wr_data   (EMPTY_ITEM),
    .clear     (1'b0),
    .load      (state == StCommit),
    .load_data (shadow_words),
    .words     (active_words)
  );

`ifdef ITEM_COLLISION_CHECK_EN
  logic collide;

  always_comb begin
    collide = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      for (int unsigned j = i + 1; j < NUM_SLOTS; j++) begin
        if (item_id(shadow_words[i]) != EMPTY_ID && item_id(shadow_words[j]) != EMPTY_ID &&
            item_loc(shadow_words[i]) == item_loc(shadow_words[j])) begin
          collide = 1'b1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StOpen;
      clear_pend   <= 1'b0;
      frame_commit <= 1'b0;
      upd_err      <= 1'b0;
`ifdef ITEM_COLLISION_CHECK_EN
      collision    <= 1'b0;
`endif
    end else begin
      frame_commit <= (state == StCommit);
      if (upd_accept && !(slot_ok && loc_ok)) upd_err <= 1'b1;
      unique case (state)
        StOpen: begin
          if (commit_now) begin
            state      <= StCommit;
            clear_pend <= clear_all;  // commit wins, clear runs right after
          end else if (clear_all) begin
            state <= StClear;
          end
        end
        StClear: state <= commit_now ? StCommit : StOpen;
        StCommit: begin
          state      <= (clear_pend || clear_all) ? StClear : StOpen;
          clear_pend <= 1'b0;
`ifdef ITEM_COLLISION_CHECK_EN
          collision  <= collide;
`endif
        end
        default: state <= StOpen;
      endcase
    end
  end

  assign item_1 = active_words[0];
  assign item_2 = active_words[1];
  assign item_3 = active_words[2];
  assign item_4 = active_words[3];
  assign item_5 = active_words[4];
  assign item_6 = active_words[5];
  assign item_7 = active_words[6];
  assign item_8 = active_words[7];
  assign item_9 = active_words[8];

endmodule

// File: doc/item_slot_manager.md
Name: item_slot_manager

Overview:
- Upstream stage of the frame-buffer controller. It owns the nine 14-bit item channels (item_1..item_9) that the controller renders.
- Game logic writes object updates through a valid/ready port into a shadow bank.
- The shadow bank is copied to the active bank once per frame, in vertical blanking, so the renderer never sees a half-updated scene.
- Item word format: [13:10] item ID (4'hF = unused), [9:8] orientation, [7:0] tile location (row*16 + col).

Parameters:
- NUM_SLOTS, 9, number of item channels (fixed at 9 to match the renderer ports).
- SCREEN_TILES, 192, number of valid tile locations (16 x 12); location >= SCREEN_TILES is rejected.
- COMMIT_LINE, 480, counter_V value at which the commit occurs (first blanking line).
- EMPTY_ITEM, 14'h3C00, word for an unused slot (ID 4'hF, orientation 0, location 0).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- counter_V  input  10  current vertical pixel counter
- counter_H  input  10  current horizontal pixel counter
- upd_valid  input  1  update request valid
- upd_ready  output  1  update accepted when valid & ready at clk edge
- upd_slot  input  4  target slot, 1..9
- upd_item  input  14  new item word for slot
- clear_all  input  1  one-cycle request to set every shadow slot to EMPTY_ITEM
- item_1 .. item_9  output  14 each  active-bank item words, registered
- frame_commit  output  1  one-cycle pulse in the cycle after the shadow-to-active copy
- upd_err  output  1  sticky error: a rejected update occurred; cleared only by reset

Behaviour:
- Reset (synchronous, active-high):
  - Shadow and active slots all = EMPTY_ITEM; state = OPEN.
  - frame_commit = 0, upd_err = 0.
  - upd_ready = 0 while reset is high; it may go high from the first cycle after reset is released.
- commit_now = (counter_V == COMMIT_LINE) && (counter_H == 0). It is combinational and evaluated every cycle.
- FSM states: OPEN, CLEAR, COMMIT.
  - OPEN: upd_ready = !commit_now && !clear_all.
    - On a handshake with a valid request, the shadow slot is written at the edge.
    - Priority: commit_now -> COMMIT; else clear_all -> CLEAR; else stay in OPEN.
  - CLEAR (1 cycle): all shadow slots = EMPTY_ITEM; upd_ready = 0.
    - If commit_now is true this cycle, go to COMMIT next; otherwise go to OPEN.
    - A cleared shadow is what COMMIT copies.
  - COMMIT (1 cycle): active <= shadow (all 9 slots at one edge); upd_ready = 0; then return to OPEN.
    - frame_commit is asserted the cycle after the COMMIT edge, coincident with the new item_n values.
- clear_all in the same cycle as commit_now: the commit is taken first and the clear is held pending. The clear executes in the cycle after COMMIT and is visible at the next frame.
- Validation of an accepted update:
  - Rejected if upd_slot is 0 or > 9, or if upd_item[7:0] >= SCREEN_TILES while upd_item[13:10] != 4'hF.
  - A rejected update consumes the handshake, leaves the shadow unchanged and sets upd_err.
  - A word with ID 4'hF is always legal and frees the slot.
- Multiple writes to the same slot between commits: last write wins.
- An update accepted in the cycle immediately before commit_now is included in that commit.
- Active outputs change only on a COMMIT edge, never mid-frame.
- counter_H/V are not required to wrap cleanly. If COMMIT_LINE is never reached, the active bank holds indefinitely (no timeout).

Optional Feature:
- Macro: ITEM_COLLISION_CHECK_EN.
- When defined:
  - Adds output collision (1 bit, registered, reset 0).
  - On each COMMIT edge, collision <= 1 if any two shadow slots, both with ID != 4'hF, share the same location (36 pairwise compares); otherwise 0.
  - The value is held until the next commit.
- When undefined: the port is absent and there is no compare logic.

Decomposition:
- Shared package (item_pkg) holds:
  - item field slice constants: ID [13:10], orientation [9:8], location [7:0];
  - EMPTY_ID = 4'hF, SCREENSIZE_H = 16, SCREENSIZE_V = 12;
  - the FSM state enum.
- Natural sub-module: item_slot_bank, holding 9 x 14-bit registers with write port, clear, and copy-in.
  - Instantiated twice (shadow, active), or once as shadow with the active bank as plain registers in the top.

Test Plan:
- Reset then release: all item_n = 14'h3C00, upd_err = 0, frame_commit = 0; upd_ready = 1 when not at the commit point.
- Write slot 3 = 14'h0545 (ID 1, orient 1, loc 0x45) at V = 100 -> item_3 unchanged until V = 480/H = 0. item_3 = 14'h0545 and frame_commit = 1 in the cycle after the COMMIT edge.
- Write slot 0, then slot 10, then slot 2 with loc 200 (ID 2) -> all rejected, shadow unchanged, upd_err = 1 and remains 1 until reset.
- Hold upd_valid high across the commit point -> upd_ready = 0 exactly in the commit_now and COMMIT cycles, with no lost or duplicated writes.
- clear_all asserted with commit_now, slots 1..9 populated -> the current commit shows the populated slots; the following frame's commit shows all 14'h3C00.
- (ITEM_COLLISION_CHECK_EN) Slots 1 and 5 both at loc 0x20 with IDs 2 and 3 -> collision = 1 after commit. Set slot 5 ID to 4'hF -> collision = 0 after the next commit.
